// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared constants for the bit-serial arithmetic blocks.
//                Holds the FSM state encoding and the default operand width.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_arith_pkg;

    // Controller state encoding (2-bit).
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Default operand width for serial datapaths.
    localparam int SERIAL_WIDTH_DEFAULT = 8;

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Combinational 1-bit full adder cell. Port order matches the
//                full_subtractor cell so the two are drop-in counterparts.
//  Ports       : A, B, Cin  - operand bits and carry-in
//                Sum        - A ^ B ^ Cin
//                Cout       - majority(A, B, Cin)
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial ripple adder. Captures two WIDTH-bit operands and
//                a carry-in on start, adds one bit per clock (LSB first)
//                through a single full_adder cell, and presents
//                {cout, sum} = a + b + cin with a one-cycle done pulse.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - begin an addition (honoured in IDLE only)
//                a, b, cin       - operands, captured on the accepted start
//                busy            - high while bits are being processed
//                done            - one-cycle pulse, sum/cout valid
//                sum, cout       - result, held until the next run begins
//  Revision    : 1.0  initial release
// ============================================================================
import serial_arith_pkg::*;

module serial_adder #(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Bit counter needs at least one bit, even for WIDTH=1.
    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_s;
    logic               w_c;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_shift;

    // ------------------------------------------------------------------
    // Per-bit datapath: one full adder fed from the operand LSBs.
    // ------------------------------------------------------------------
    full_adder u_fa (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Cin  (r_carry),
        .Sum  (w_s),
        .Cout (w_c)
    );

    assign w_last = (r_cnt == c_CNT_LAST);

    // New sum bit enters at the MSB; after WIDTH shifts the LSB-first
    // stream has landed in natural bit order.
    if (WIDTH == 1) begin : g_sum_w1
        assign w_sum_shift = w_s;
    end else begin : g_sum_wn
        assign w_sum_shift = {w_s, r_sum[WIDTH-1:1]};
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE:             w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    assign sum  = r_sum;
    assign cout = r_cout;

    // ------------------------------------------------------------------
    // Datapath registers. sum/cout are left untouched in IDLE and DONE so
    // the previous result stays visible until the next run starts shifting.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_sum   <= w_sum_shift;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    if (w_last) begin
                        r_cout <= w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. An 8-bit instance is
//                exercised with directed and random operands against a plain
//                arithmetic reference; a 1-bit instance is swept over all
//                input combinations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    localparam int c_W = 8;

    logic           clk = 1'b0;
    logic           rst;

    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           cin;
    logic           busy;
    logic           done;
    logic [c_W-1:0] sum;
    logic           cout;

    logic           start1;
    logic [0:0]     a1;
    logic [0:0]     b1;
    logic           cin1;
    logic           busy1;
    logic           done1;
    logic [0:0]     sum1;
    logic           cout1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(c_W)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) u_dut_w1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one addition on the 8-bit instance and check the result, the
    // busy/done timing and the result hold after done. Entered and left on
    // a falling edge; on return the DUT is in IDLE and can take a new start.
    task automatic run_op(input logic [c_W-1:0] a_i, input logic [c_W-1:0] b_i,
                          input logic ci, input string tag);
        logic [c_W:0] exp;
        int           ncyc;
        int           nbusy;
        exp = {1'b0, a_i} + {1'b0, b_i} + {{c_W{1'b0}}, ci};
        a     = a_i;
        b     = b_i;
        cin   = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // operands must not be observed after the accept cycle
        a     = c_W'($urandom);
        b     = c_W'($urandom);
        cin   = 1'($urandom);
        ncyc  = 1;
        nbusy = 0;
        while (!done && ncyc < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            ncyc++;
        end
        chk({tag, " latency"}, 64'(ncyc), 64'(c_W + 1));
        chk({tag, " busy_cycles"}, 64'(nbusy), 64'(c_W));
        chk({tag, " done"}, 64'(done), 64'(1));
        chk({tag, " busy_in_done"}, 64'(busy), 64'(0));
        chk({tag, " result"}, 64'({cout, sum}), 64'(exp));
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'(done), 64'(0));
        chk({tag, " result_held"}, 64'({cout, sum}), 64'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int ndone;
        logic [c_W:0] got_res;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst sum",  64'(sum),  64'(0));
        chk("rst cout", 64'(cout), 64'(0));
        chk("rst w1",   64'({busy1, done1, sum1, cout1}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        run_op(8'h00, 8'h00, 1'b0, "zero");
        run_op(8'hFF, 8'h01, 1'b0, "ff+01");
        run_op(8'hA5, 8'h5A, 1'b1, "a5+5a+1");
        run_op(8'h12, 8'h34, 1'b0, "12+34");

        // start during RUN is ignored
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        got_res = '0;
        for (int i = 0; i < 24; i++) begin
            if (done) begin
                ndone++;
                got_res = {cout, sum};
            end
            @(negedge clk);
        end
        chk("ignore done_count", 64'(ndone), 64'(1));
        chk("ignore result", 64'(got_res), 64'(9'h010));

        // reset mid-operation aborts the run
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst sum",  64'(sum),  64'(0));
        chk("midrst cout", 64'(cout), 64'(0));
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        chk("midrst no_done", 64'(ndone), 64'(0));
        run_op(8'h80, 8'h80, 1'b0, "80+80");

        // start together with reset is dropped
        a = 8'h11; b = 8'h22; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        chk("rst_start busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("rst_start idle", 64'(busy), 64'(0));

        // back-to-back: second start issued in the IDLE cycle after done
        run_op(8'h7F, 8'h01, 1'b0, "b2b_1");
        run_op(8'h01, 8'h01, 1'b0, "b2b_2");

        // randomized operands
        for (int i = 0; i < 500; i++) begin
            run_op(c_W'($urandom), c_W'($urandom), 1'($urandom), "rand");
        end

        // WIDTH=1 exhaustive
        for (int k = 0; k < 8; k++) begin
            int exp1;
            exp1  = k[2] + k[1] + k[0];
            a1    = 1'(k[2]);
            b1    = 1'(k[1]);
            cin1  = k[0];
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            chk("w1 busy", 64'(busy1), 64'(1));
            @(negedge clk);
            chk("w1 done", 64'(done1), 64'(1));
            chk("w1 result", 64'({cout1, sum1}), 64'(exp1));
            @(negedge clk);
            chk("w1 done_pulse", 64'(done1), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
